// File: rtl/ps2_scancode_decoder_if.sv
// ============================================================================
//  Module   : ps2_scancode_decoder_if
//  Purpose  : Byte-in / key-event-out bundle for the PS/2 scan-code decoder.
//             The master side is the byte source plus the event consumer.
//             The slave side is the decoder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ps2_scancode_decoder_if;
  logic       dataEnable;
  logic [7:0] data;
  logic       eventRead;
  logic       clearOverflow;
  logic       eventValid;
  logic [7:0] eventCode;
  logic       eventExtended;
  logic       eventReleased;
  logic [7:0] eventAscii;
  logic       shiftActive;
  logic       ctrlActive;
  logic       capsLock;
  logic       overflow;

  modport master (
    output dataEnable, data, eventRead, clearOverflow,
    input  eventValid, eventCode, eventExtended, eventReleased, eventAscii,
    input  shiftActive, ctrlActive, capsLock, overflow
  );

  modport slave (
    input  dataEnable, data, eventRead, clearOverflow,
    output eventValid, eventCode, eventExtended, eventReleased, eventAscii,
    output shiftActive, ctrlActive, capsLock, overflow
  );
endinterface

`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
// ============================================================================
//  Module   : ps2_scancode_decoder
//  Purpose  : Collapses Set 2 prefix sequences (E0/F0/E1) into key events.
//             Tracks shift, ctrl and caps-lock, and attaches ASCII.
//             Queues events in a small shift-register FIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ps2_scancode_decoder_if.slave   bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE_E0   = 3'd1,
    S_PRE_F0   = 3'd2,
    S_PRE_E0F0 = 3'd3,
    S_SKIP     = 3'd4
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
    logic [7:0] ascii;
  } entry_t;

  state_t          state_q;
  logic [2:0]      skip_q;
  logic [TW-1:0]   tmo_q;
  logic            push_q;
  entry_t          entry_q;
  logic            lshift_q, rshift_q, lctrl_q, rctrl_q, caps_q, caps_held_q;
  entry_t          fifo_q [FIFO_DEPTH];
  logic [CW-1:0]   count_q;
  logic            overflow_q;

  logic            emit_d, ext_d, rel_d;
  logic [7:0]      ascii_d;
  logic            w_shift, w_ctrl, w_pop, w_full, w_do_push, w_drop;
  logic [AW-1:0]   w_slot;

  // Returns 1..26 for the letter keys a..z, and 0 for any other key.
  function automatic logic [4:0] letter_idx(input logic [7:0] c);
    case (c)
      8'h1C: return 5'd1;   8'h32: return 5'd2;   8'h21: return 5'd3;
      8'h23: return 5'd4;   8'h24: return 5'd5;   8'h2B: return 5'd6;
      8'h34: return 5'd7;   8'h33: return 5'd8;   8'h43: return 5'd9;
      8'h3B: return 5'd10;  8'h42: return 5'd11;  8'h4B: return 5'd12;
      8'h3A: return 5'd13;  8'h31: return 5'd14;  8'h44: return 5'd15;
      8'h4D: return 5'd16;  8'h15: return 5'd17;  8'h2D: return 5'd18;
      8'h1B: return 5'd19;  8'h2C: return 5'd20;  8'h3C: return 5'd21;
      8'h2A: return 5'd22;  8'h1D: return 5'd23;  8'h22: return 5'd24;
      8'h35: return 5'd25;  8'h1A: return 5'd26;
      default: return 5'd0;
    endcase
  endfunction

  // Translates a plain make code to ASCII using the modifier state in force before this key.
  function automatic logic [7:0] ascii_lookup(input logic [7:0] c, input logic shift,
                                              input logic ctrl, input logic caps);
    logic [4:0] idx;
    idx = letter_idx(c);
    if (idx != 5'd0) begin
      if (ctrl)              return {3'b000, idx};
      else if (shift ^ caps) return 8'h40 + {3'b000, idx};
      else                   return 8'h60 + {3'b000, idx};
    end
    case (c)
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
      8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
      8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
      8'h46: return 8'h39;  8'h29: return 8'h20;  8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  assign w_shift = lshift_q | rshift_q;
  assign w_ctrl  = lctrl_q | rctrl_q;

  // Decide whether the incoming byte completes an event, and with which flags.
  always_comb begin
    emit_d = 1'b0;
    ext_d  = 1'b0;
    rel_d  = 1'b0;
    if (bus.dataEnable) begin
      case (state_q)
        S_IDLE: begin
          case (bus.data)
            8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE: emit_d = 1'b0;
            default: emit_d = 1'b1;
          endcase
        end
        S_PRE_E0: begin
          if (bus.data != 8'hF0 && bus.data != 8'hE0 && bus.data != 8'h12) begin
            emit_d = 1'b1;
            ext_d  = 1'b1;
          end
        end
        S_PRE_F0: begin
          if (bus.data != 8'hE0 && bus.data != 8'hF0) begin
            emit_d = 1'b1;
            rel_d  = 1'b1;
          end
        end
        S_PRE_E0F0: begin
          if (bus.data != 8'h12) begin
            emit_d = 1'b1;
            ext_d  = 1'b1;
            rel_d  = 1'b1;
          end
        end
        default: emit_d = 1'b0;
      endcase
    end
    ascii_d = (ext_d | rel_d) ? 8'h00 : ascii_lookup(bus.data, w_shift, w_ctrl, caps_q);
  end

  // Prefix FSM with Pause-sequence skip and idle timeout; registers the event for the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      skip_q  <= 3'd0;
      tmo_q   <= '0;
      push_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      push_q <= emit_d;
      if (emit_d) entry_q <= {ext_d, rel_d, bus.data, ascii_d};
      if (bus.dataEnable) begin
        tmo_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (bus.data == 8'hE0)      state_q <= S_PRE_E0;
            else if (bus.data == 8'hF0) state_q <= S_PRE_F0;
            else if (bus.data == 8'hE1) begin
              state_q <= S_SKIP;
              skip_q  <= 3'd7;
            end
          end
          S_PRE_E0: begin
            if (bus.data == 8'hF0)      state_q <= S_PRE_E0F0;
            else if (bus.data != 8'hE0) state_q <= S_IDLE;
          end
          S_PRE_F0: begin
            if (bus.data == 8'hE0)      state_q <= S_PRE_E0;
            else if (bus.data != 8'hF0) state_q <= S_IDLE;
          end
          S_SKIP: begin
            skip_q <= skip_q - 3'd1;
            if (skip_q <= 3'd1) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        // An abandoned prefix must not glue itself onto a much later key.
        if (tmo_q == TMO_LAST) begin
          state_q <= S_IDLE;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  // Modifier tracking on the same edge that the event is decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else if (emit_d) begin
      case (bus.data)
        8'h12: if (!ext_d) lshift_q <= !rel_d;
        8'h59: if (!ext_d) rshift_q <= !rel_d;
        8'h14: begin
          if (ext_d) rctrl_q <= !rel_d;
          else       lctrl_q <= !rel_d;
        end
        8'h58: begin
          if (rel_d) caps_held_q <= 1'b0;
          else begin
            // Typematic repeats arrive while held and must not toggle again.
            if (!caps_held_q) caps_q <= ~caps_q;
            caps_held_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_pop     = bus.eventRead && (count_q != '0);
  assign w_full    = (count_q == CW'(FIFO_DEPTH));
  assign w_do_push = push_q && (!w_full || w_pop);
  assign w_drop    = push_q && w_full && !w_pop;
  assign w_slot    = w_pop ? AW'(count_q - CW'(1)) : AW'(count_q);

  // Shift-register FIFO: entry 0 is always the head, so the outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_q[i] <= fifo_q[i+1];
        fifo_q[FIFO_DEPTH-1] <= '0;
      end
      if (w_do_push) fifo_q[w_slot] <= entry_q;
      count_q <= count_q + CW'(w_do_push) - CW'(w_pop);
      if (w_drop)                 overflow_q <= 1'b1;
      else if (bus.clearOverflow) overflow_q <= 1'b0;
    end
  end

  assign bus.eventValid    = (count_q != '0);
  assign bus.eventCode     = fifo_q[0].code;
  assign bus.eventExtended = fifo_q[0].ext;
  assign bus.eventReleased = fifo_q[0].rel;
  assign bus.eventAscii    = fifo_q[0].ascii;
  assign bus.shiftActive   = w_shift;
  assign bus.ctrlActive    = w_ctrl;
  assign bus.capsLock      = caps_q;
  assign bus.overflow      = overflow_q;

endmodule

`default_nettype wire

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver. Consumes its one-cycle byte strobe and 8-bit byte (Scan Code Set 2).
- Collapses E0/F0/E1 prefix sequences into single key events with extended/released flags.
- Tracks shift, ctrl and caps-lock state and attaches an ASCII translation.
- Buffers events in a small FIFO drained by the consumer with a read strobe.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries (power of two, ≥2).
- TIMEOUT_CYCLES, 1000000, idle cycles after which a pending prefix is abandoned.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- dataEnable  in  1  one-cycle strobe: byte valid on data
- data  in  8  received scan-code byte
- eventRead  in  1  pop FIFO head (ignored when empty)
- clearOverflow  in  1  clears overflow flag
- eventValid  out  1  FIFO not empty
- eventCode  out  8  head: scan code without prefixes
- eventExtended  out  1  head: E0 prefix was present
- eventReleased  out  1  head: F0 prefix was present
- eventAscii  out  8  head: ASCII, 0x00 if none
- shiftActive  out  1  left or right shift held
- ctrlActive  out  1  ctrl held
- capsLock  out  1  caps-lock toggle state
- overflow  out  1  sticky: event dropped on full FIFO

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; FIFO empty; eventValid=0; head fields 0.
  - shiftActive, ctrlActive, capsLock, overflow = 0; timeout counter = 0.
- FSM states: IDLE, PRE_E0, PRE_F0, PRE_E0F0, SKIP. Transitions happen only on a cycle with dataEnable=1, except timeout.
- IDLE:
  - E0 -> PRE_E0; F0 -> PRE_F0.
  - E1 -> SKIP, skip counter=7.
  - 00, FF, AA, FA, FE, EE: discard, stay in IDLE.
  - Any other byte: emit make event (ext=0, rel=0).
- PRE_E0:
  - F0 -> PRE_E0F0; E0 -> stay.
  - 12 (fake shift): discard -> IDLE.
  - Any other byte: emit ext=1, rel=0 -> IDLE.
- PRE_F0:
  - E0 -> PRE_E0 and F0 -> PRE_F0 (stale F0 dropped).
  - Any other byte: emit ext=0, rel=1 -> IDLE.
- PRE_E0F0:
  - 12: discard -> IDLE.
  - Any other byte: emit ext=1, rel=1 -> IDLE.
- SKIP: each byte decrements the skip counter; at 0 -> IDLE. No events emitted (Pause key).
- Timeout:
  - In any non-IDLE state, the counter increments every cycle without dataEnable and resets to 0 on dataEnable.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, nothing emitted. The counter is held at 0 in IDLE.
- Modifiers (updated on the cycle the event is emitted):
  - Codes 12 and 59 (ext=0) drive independent left/right held bits; shiftActive = OR of the two.
  - Code 14 (ext 0 or 1) drives independent left/right ctrl bits; ctrlActive = OR.
  - Code 58 make toggles capsLock only if caps is not already held (typematic repeat ignored); release clears held.
- ASCII (computed from modifier state before the current event applies):
  - Released, extended or unmapped events give 0x00.
  - Letters follow the US Set 2 map (1C=a … 1A=z). Uppercase when shiftActive XOR capsLock.
  - Main-row digits 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'-'9', unaffected by shift.
  - 29=0x20, 5A=0x0D, 66=0x08.
  - With ctrlActive, letters give 0x01-0x1A.
- Latency:
  - Byte strobe in cycle N -> push in N+1.
  - eventValid and head fields valid from N+2 when the FIFO was empty.
  - Back-to-back strobes every cycle must be accepted.
- FIFO:
  - Entry = {ext, rel, code, ascii}. Head registered; eventRead pops on the same edge.
  - Push while full without pop: entry dropped, overflow=1.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: push succeeds, pop ignored.
  - clearOverflow in the same cycle as a new drop: overflow stays 1.

Test Plan:
- Bytes 1C, F0 1C -> events {1C,ext0,rel0,'a'=0x61}, {1C,ext0,rel1,0x00}.
- 12, 1C, F0 12, 1C -> 'A' (0x41) then 'a' (0x61); shiftActive 1 then 0.
- 58, F0 58, 58, 58, F0 58, 15 -> capsLock toggles once per press, ends 0; 15 gives 'q'.
- E0 12 E0 75, E0 F0 75 E0 F0 12 -> only {75,ext1,rel0} and {75,ext1,rel1}.
- E1 14 77 E1 F0 14 F0 77, then 29 -> a single event {29,...,0x20}.
- FIFO_DEPTH+1 makes, no reads -> overflow=1, first FIFO_DEPTH entries intact. Full plus simultaneous read and push -> no new overflow. Pulse rst_n low mid-sequence -> all outputs 0 immediately. E0 then idle for TIMEOUT_CYCLES, then 1C -> non-extended event.
